puf_eval_ctrl: RTL and testbench
================================

Name: puf_eval_ctrl

Overview:
- Sequencer that drives the PDL arbiter-PUF race and consumes the arbiter flip-flop's output.
- For each accepted challenge it applies the challenge to the delay lines and fires the race N_EVAL times.
- It samples the synchronised arbiter bit after every race, majority-votes the samples into one response bit, and shifts that bit into a RESP_BITS response word.
- The word is handed to the Ethernet/reporting side through a valid/ready handshake.

Parameters:
- CHAL_W, 64: challenge width applied to the PDL delay stages.
- N_EVAL, 15: races per challenge. Must be odd and >=1.
- SETTLE_CYC, 8: cycles for each relax phase and each fire phase. Must be >=3 to cover the 2-flop synchroniser.
- RESP_BITS, 32: response bits collected per output word.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  challenge accepted when chal_valid && chal_ready.
- chal_data  in  CHAL_W  challenge.
- pdl_chal  out  CHAL_W  registered challenge driven to the delay-line selects.
- race_start  out  1  race launch signal into both delay paths (rising edge launches).
- arbiter_q  in  1  arbiter flip-flop output. Asynchronous to clk.
- resp_valid  out  1  response word available.
- resp_ready  in  1  consumer accepts the word.
- resp_data  out  RESP_BITS  majority-voted response. The first challenge's bit ends in the MSB.
- unstable_mask  out  RESP_BITS  bit set when the votes for that challenge were not unanimous.

Behaviour:
- Reset: all state is reset on a clk edge with rst_n=0, and reset is asynchronous to nothing else.
  - state=IDLE; pdl_chal, race_start, resp_valid, resp_data, unstable_mask, all counters and synchroniser flops = 0.
  - chal_ready=1 from the first cycle after reset release.
- Synchroniser: arbiter_q passes through 2 flops to give q_s. No other logic uses arbiter_q directly.
- chal_ready = (state==IDLE).
- FSM:
  - IDLE: on chal_valid && chal_ready, latch pdl_chal<=chal_data, clear ones/eval counters, go to RELAX.
  - RELAX: race_start=0 for SETTLE_CYC cycles. This lets the challenge and delay lines settle. Then go to FIRE.
  - FIRE: race_start=1 for SETTLE_CYC cycles, then go to SAMPLE.
  - SAMPLE: one cycle with race_start still 1. ones+=q_s and eval_cnt+=1. If eval_cnt reaches N_EVAL go to DECIDE, else go to RELAX (race_start drops).
  - DECIDE: one cycle.
    - bit = (ones > N_EVAL/2).
    - unst = (ones!=0 && ones!=N_EVAL).
    - resp_data <= {resp_data[RESP_BITS-2:0], bit}; unstable_mask is shifted the same way with unst.
    - bit_cnt+=1. If bit_cnt reaches RESP_BITS go to OUT, else go to IDLE.
  - OUT: resp_valid=1, with resp_data and unstable_mask held stable. On resp_ready, resp_valid becomes 0 on the next edge, bit_cnt clears, and the FSM goes to IDLE. resp_data is not cleared, because the shift overwrites it.
- Latency per challenge: 1 accept cycle + N_EVAL*(2*SETTLE_CYC+1) + 1 decide cycle. With defaults this is 1+15*17+1 = 257 cycles.
- Exactly N_EVAL race_start rising edges occur per challenge. race_start is 0 in IDLE, DECIDE and OUT.
- pdl_chal changes only in IDLE on accept, so it never changes while race_start=1.
- Widths: ones and eval_cnt are $clog2(N_EVAL+1) bits; bit_cnt is $clog2(RESP_BITS+1) bits. No wrap is possible.
- Backpressure: while in OUT no challenge is accepted (chal_ready=0). resp_ready high outside OUT is ignored.
- Reset mid-operation discards the partial response:
  - race_start is 0 after that edge.
  - bit_cnt is cleared.
  - Any challenge in flight is dropped; the upstream source must re-issue it.

Decomposition:
- Shared package puf_pkg holds:
  - the state enum (IDLE, RELAX, FIRE, SAMPLE, DECIDE, OUT);
  - default parameter constants;
  - a function for the majority threshold N_EVAL/2.
- One natural sub-module: sync_2ff (2-flop synchroniser for arbiter_q). It is reusable by other arbiter consumers.

Test Plan:
Bench settings for all scenarios: N_EVAL=5, SETTLE_CYC=4, RESP_BITS=4, giving 47 cycles per challenge.
1. Reset: hold rst_n=0 for 3 cycles with garbage inputs -> all outputs 0; chal_ready=1 on the first cycle after release; race_start stays 0 until a challenge is accepted.
2. Tie arbiter_q=1 and offer 4 challenges back-to-back -> each has exactly 5 race_start pulses of 5 cycles high; resp_valid rises after 4*47 cycles; resp_data=4'b1111; unstable_mask=4'b0000.
3. Model q=1,0,1,0 per challenge, constant within each challenge -> resp_data=4'b1010, unstable_mask=0; pdl_chal equals each challenge while its races run.
4. Noisy challenge with samples 1,1,0,1,0 (3/5) -> bit 1, unst 1. Next challenge with samples 0,1,0,0,1 (2/5) -> bit 0, unst 1. Two following unanimous-1 challenges -> resp_data=4'b1011, unstable_mask=4'b1100.
5. Backpressure: hold resp_ready=0 for 20 cycles in OUT -> resp_valid=1 and data stable; chal_ready=0 with chal_valid=1 and nothing accepted. Raise resp_ready -> resp_valid=0 and chal_ready=1 on the next edge.
6. Assert rst_n=0 during the 2nd FIRE of challenge 2 -> race_start=0 after that edge. After release, 4 fresh challenges of all-1 give resp_data=4'b1111; no stale bit from before the reset appears.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF evaluation controller and its helpers.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RELAX  = 3'd1,
        FIRE   = 3'd2,
        SAMPLE = 3'd3,
        DECIDE = 3'd4,
        OUT    = 3'd5
    } puf_state_e;

    localparam int DEF_CHAL_W     = 64;
    localparam int DEF_N_EVAL     = 15;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_RESP_BITS  = 32;

    // A response bit is 1 when strictly more than this many races returned 1.
    function automatic int unsigned maj_threshold(input int unsigned n_eval);
        return n_eval / 32'd2;
    endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Challenge in / response out handshake bundle of the PUF evaluation controller.
interface puf_eval_ctrl_if #(
    parameter int CHAL_W    = 64,
    parameter int RESP_BITS = 32
) ();

    logic                 chal_valid;
    logic                 chal_ready;
    logic [CHAL_W-1:0]    chal_data;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RESP_BITS-1:0] resp_data;
    logic [RESP_BITS-1:0] unstable_mask;

    // Challenge source and response consumer.
    modport master (
        output chal_valid, chal_data, resp_ready,
        input  chal_ready, resp_valid, resp_data, unstable_mask
    );

    // The controller.
    modport slave (
        input  chal_valid, chal_data, resp_ready,
        output chal_ready, resp_valid, resp_data, unstable_mask
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit (e.g. an arbiter output).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two back-to-back flops give the first one a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF sequencer: per challenge, races the delay lines N_EVAL times,
// majority-votes the arbiter samples and shifts the bit into a response word.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int CHAL_W     = DEF_CHAL_W,
    parameter int N_EVAL     = DEF_N_EVAL,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int RESP_BITS  = DEF_RESP_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    puf_eval_ctrl_if.slave    bus,
    output logic [CHAL_W-1:0] pdl_chal,
    output logic              race_start,
    input  logic              arbiter_q
);

    localparam int CNT_W = $clog2(N_EVAL + 1);
    localparam int BIT_W = $clog2(RESP_BITS + 1);
    localparam int SET_W = $clog2(SETTLE_CYC);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] EVAL_LAST   = CNT_W'(N_EVAL - 1);
    localparam logic [CNT_W-1:0] EVAL_ALL    = CNT_W'(N_EVAL);
    localparam logic [CNT_W-1:0] VOTE_THR    = CNT_W'(maj_threshold(N_EVAL));
    localparam logic [BIT_W-1:0] BITS_LAST   = BIT_W'(RESP_BITS - 1);

    puf_state_e           state_r,    state_nxt_s;
    logic [SET_W-1:0]     set_cnt_r,  set_cnt_nxt_s;
    logic [CNT_W-1:0]     eval_cnt_r, eval_cnt_nxt_s;
    logic [CNT_W-1:0]     ones_r,     ones_nxt_s;
    logic [BIT_W-1:0]     bit_cnt_r,  bit_cnt_nxt_s;
    logic [CHAL_W-1:0]    pdl_chal_r, pdl_chal_nxt_s;
    logic [RESP_BITS-1:0] resp_r,     resp_nxt_s;
    logic [RESP_BITS-1:0] unst_r,     unst_nxt_s;
    logic                 race_start_r;
    logic                 resp_valid_r;
    logic                 q_s;
    logic                 vote_bit_s;
    logic                 vote_unst_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (arbiter_q),
        .q     (q_s)
    );

    assign vote_bit_s  = (ones_r > VOTE_THR);
    assign vote_unst_s = (ones_r != {CNT_W{1'b0}}) && (ones_r != EVAL_ALL);

    // Next-state and datapath decisions for the race sequence.
    always_comb begin
        state_nxt_s    = state_r;
        set_cnt_nxt_s  = set_cnt_r;
        eval_cnt_nxt_s = eval_cnt_r;
        ones_nxt_s     = ones_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        pdl_chal_nxt_s = pdl_chal_r;
        resp_nxt_s     = resp_r;
        unst_nxt_s     = unst_r;
        case (state_r)
            IDLE: begin
                if (bus.chal_valid) begin
                    pdl_chal_nxt_s = bus.chal_data;
                    ones_nxt_s     = {CNT_W{1'b0}};
                    eval_cnt_nxt_s = {CNT_W{1'b0}};
                    set_cnt_nxt_s  = {SET_W{1'b0}};
                    state_nxt_s    = RELAX;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RELAX: begin
                if (set_cnt_r == SETTLE_LAST) begin
                    set_cnt_nxt_s = {SET_W{1'b0}};
                    state_nxt_s   = FIRE;
                end else begin
                    set_cnt_nxt_s = set_cnt_r + SET_W'(1);
                end
            end
            FIRE: begin
                if (set_cnt_r == SETTLE_LAST) begin
                    set_cnt_nxt_s = {SET_W{1'b0}};
                    state_nxt_s   = SAMPLE;
                end else begin
                    set_cnt_nxt_s = set_cnt_r + SET_W'(1);
                end
            end
            SAMPLE: begin
                ones_nxt_s     = ones_r + CNT_W'(q_s);
                eval_cnt_nxt_s = eval_cnt_r + CNT_W'(1);
                if (eval_cnt_r == EVAL_LAST) begin
                    state_nxt_s = DECIDE;
                end else begin
                    state_nxt_s = RELAX;
                end
            end
            DECIDE: begin
                resp_nxt_s    = {resp_r[RESP_BITS-2:0], vote_bit_s};
                unst_nxt_s    = {unst_r[RESP_BITS-2:0], vote_unst_s};
                bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                if (bit_cnt_r == BITS_LAST) begin
                    state_nxt_s = OUT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OUT: begin
                if (bus.resp_ready) begin
                    bit_cnt_nxt_s = {BIT_W{1'b0}};
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; race_start/resp_valid are decoded one step early so they leave flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            set_cnt_r    <= {SET_W{1'b0}};
            eval_cnt_r   <= {CNT_W{1'b0}};
            ones_r       <= {CNT_W{1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            pdl_chal_r   <= {CHAL_W{1'b0}};
            resp_r       <= {RESP_BITS{1'b0}};
            unst_r       <= {RESP_BITS{1'b0}};
            race_start_r <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            set_cnt_r    <= set_cnt_nxt_s;
            eval_cnt_r   <= eval_cnt_nxt_s;
            ones_r       <= ones_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            pdl_chal_r   <= pdl_chal_nxt_s;
            resp_r       <= resp_nxt_s;
            unst_r       <= unst_nxt_s;
            race_start_r <= (state_nxt_s == FIRE) || (state_nxt_s == SAMPLE);
            resp_valid_r <= (state_nxt_s == OUT);
        end
    end

    assign bus.chal_ready    = (state_r == IDLE);
    assign bus.resp_valid    = resp_valid_r;
    assign bus.resp_data     = resp_r;
    assign bus.unstable_mask = unst_r;
    assign pdl_chal          = pdl_chal_r;
    assign race_start        = race_start_r;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl with a timeline-level reference model.
module tb_puf_eval_ctrl;

    localparam int CHAL_W    = 64;
    localparam int N_EVAL    = 5;
    localparam int SETTLE    = 4;
    localparam int RESP_BITS = 4;
    localparam int T_RACE    = 2 * SETTLE + 1;      // relax + fire + sample
    localparam int T_DECIDE  = N_EVAL * T_RACE;     // cycle index of the decide cycle

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CHAL_W-1:0] pdl_chal;
    logic              race_start;
    logic              arbiter_q;

    puf_eval_ctrl_if #(.CHAL_W(CHAL_W), .RESP_BITS(RESP_BITS)) bus ();

    puf_eval_ctrl #(
        .CHAL_W     (CHAL_W),
        .N_EVAL     (N_EVAL),
        .SETTLE_CYC (SETTLE),
        .RESP_BITS  (RESP_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .pdl_chal   (pdl_chal),
        .race_start (race_start),
        .arbiter_q  (arbiter_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired waiting for DUT (t=%0t)", name, $time);
    endtask

    // Per-race arbiter outcome of the challenge being offered (bit k = race k).
    logic [N_EVAL-1:0] cur_pat = '1;

    // Reference model: time since accept, collected bits, handshake state.
    bit                   m_valid = 1'b0;
    bit                   m_busy  = 1'b0;
    bit                   m_out   = 1'b0;
    int                   m_t     = 0;
    int                   m_bits  = 0;
    logic [N_EVAL-1:0]    m_pat   = '0;
    logic [CHAL_W-1:0]    m_chal  = '0;
    logic [RESP_BITS-1:0] m_resp  = '0;
    logic [RESP_BITS-1:0] m_unst  = '0;
    int                   rise_cnt = 0;
    int                   high_cnt = 0;
    logic                 prev_rs  = 1'b0;

    // Compare DUT against the model each negedge, then step the model over the next edge.
    initial begin
        arbiter_q = 1'b0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("chal_ready", bus.chal_ready, !m_busy && !m_out);
                check("race_start", race_start,
                      m_busy && (m_t < T_DECIDE) && ((m_t % T_RACE) >= SETTLE));
                check("resp_valid", bus.resp_valid, m_out);
                check("pdl_chal", pdl_chal, m_chal);
                check("resp_data", bus.resp_data, m_resp);
                check("unstable_mask", bus.unstable_mask, m_unst);
                if (race_start === 1'b1) high_cnt++;
                if (race_start === 1'b1 && prev_rs === 1'b0) rise_cnt++;
                prev_rs = race_start;
            end
            if (!rst_n) begin
                m_valid = 1'b1;
                m_busy  = 1'b0;
                m_out   = 1'b0;
                m_t     = 0;
                m_bits  = 0;
                m_chal  = '0;
                m_resp  = '0;
                m_unst  = '0;
            end else if (m_valid) begin
                if (m_busy) begin
                    if (m_t == T_DECIDE) begin
                        int ones;
                        ones   = $countones(m_pat);
                        m_resp = {m_resp[RESP_BITS-2:0], ones > (N_EVAL / 2)};
                        m_unst = {m_unst[RESP_BITS-2:0], (ones != 0) && (ones != N_EVAL)};
                        m_bits++;
                        m_busy = 1'b0;
                        if (m_bits == RESP_BITS) m_out = 1'b1;
                    end else begin
                        m_t++;
                    end
                end else if (m_out) begin
                    if (bus.resp_ready) begin
                        m_out  = 1'b0;
                        m_bits = 0;
                    end
                end else if (bus.chal_valid) begin
                    m_busy = 1'b1;
                    m_t    = 0;
                    m_chal = bus.chal_data;
                    m_pat  = cur_pat;
                end
            end
            arbiter_q = (m_busy && m_t < T_DECIDE) ? m_pat[m_t / T_RACE] : 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [CHAL_W-1:0] d, input logic [N_EVAL-1:0] p, output int t_seen);
        bit acc;
        acc    = 1'b0;
        t_seen = 0;
        bus.chal_valid = 1'b1;
        bus.chal_data  = d;
        cur_pat        = p;
        for (int n = 0; n < 500 && !acc; n++) begin
            @(negedge clk);
            if (bus.chal_ready === 1'b1) begin
                acc    = 1'b1;
                t_seen = cyc;
            end
        end
        if (!acc) timeout("offer");
        tick();
        bus.chal_valid = 1'b0;
    endtask

    task automatic wait_out(output int t_seen);
        bit got;
        got    = 1'b0;
        t_seen = 0;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                got    = 1'b1;
                t_seen = cyc;
            end
        end
        if (!got) timeout("wait_resp_valid");
        tick();
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        int t0, t1, tmp, r0, h0;
        logic [CHAL_W-1:0] last_d;

        // 1: reset with garbage on the inputs
        rst_n          = 1'b0;
        bus.chal_valid = 1'b1;
        bus.chal_data  = 64'hDEAD_BEEF_CAFE_F00D;
        bus.resp_ready = 1'b1;
        repeat (3) tick();
        check("rst_race_start", race_start, 1'b0);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_pdl_chal", pdl_chal, 64'h0);
        check("rst_resp_data", bus.resp_data, 4'h0);
        check("rst_unst", bus.unstable_mask, 4'h0);
        rst_n          = 1'b1;
        bus.chal_valid = 1'b0;
        bus.resp_ready = 1'b0;
        tick();
        check("post_rst_chal_ready", bus.chal_ready, 1'b1);
        repeat (3) tick();
        check("idle_race_start", race_start, 1'b0);

        // 2: arbiter tied to 1, four challenges back-to-back
        r0 = rise_cnt;
        h0 = high_cnt;
        offer(64'h0123_4567_89AB_CDEF, 5'b11111, t0);
        for (int i = 1; i < 4; i++) offer(64'h0123_4567_89AB_CDEF + 64'(i), 5'b11111, tmp);
        wait_out(t1);
        check("resp_valid_latency", 64'(t1 - t0), 64'd188);
        check("rise_count", 64'(rise_cnt - r0), 64'd20);
        check("high_cycles", 64'(high_cnt - h0), 64'd100);
        check("t2_resp_data", bus.resp_data, 4'b1111);
        check("t2_unst", bus.unstable_mask, 4'b0000);
        consume();

        // 3: constant outcome per challenge, alternating 1/0
        for (int i = 0; i < 4; i++) begin
            offer({$urandom, $urandom}, (i % 2 == 0) ? 5'b11111 : 5'b00000, tmp);
        end
        wait_out(tmp);
        check("t3_resp_data", bus.resp_data, 4'b1010);
        check("t3_unst", bus.unstable_mask, 4'b0000);
        consume();

        // 4: noisy challenges (races 1,1,0,1,0 then 0,1,0,0,1), then two steady 1s
        offer(64'hAAAA_0000_5555_0001, 5'b01011, tmp);
        offer(64'hAAAA_0000_5555_0002, 5'b10010, tmp);
        offer(64'hAAAA_0000_5555_0003, 5'b11111, tmp);
        last_d = 64'hAAAA_0000_5555_0004;
        offer(last_d, 5'b11111, tmp);
        wait_out(tmp);
        check("t4_resp_data", bus.resp_data, 4'b1011);
        check("t4_unst", bus.unstable_mask, 4'b1100);

        // 5: backpressure with a challenge waiting
        bus.chal_valid = 1'b1;
        bus.chal_data  = 64'h5555_5555_5555_5555;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 4) begin
                check("bp_resp_valid", bus.resp_valid, 1'b1);
                check("bp_resp_data", bus.resp_data, 4'b1011);
                check("bp_chal_ready", bus.chal_ready, 1'b0);
                check("bp_pdl_chal", pdl_chal, last_d);
            end
        end
        bus.chal_valid = 1'b0;
        consume();
        check("bp_release_valid", bus.resp_valid, 1'b0);
        check("bp_release_ready", bus.chal_ready, 1'b1);

        // 6: reset during the second fire phase of the second challenge
        offer(64'h1111_2222_3333_4444, 5'b00000, tmp);
        offer(64'h5555_6666_7777_8888, 5'b11111, tmp);
        repeat (13) tick();
        check("mid_fire_race_start", race_start, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_race_start", race_start, 1'b0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) offer(64'hF0F0_0000_0000_0000 + 64'(i), 5'b11111, tmp);
        wait_out(tmp);
        check("t6_resp_data", bus.resp_data, 4'b1111);
        check("t6_unst", bus.unstable_mask, 4'b0000);
        consume();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
